// File: rtl/pll_startup_seq.sv
// pll_startup_seq: brings up the iCE40 PLL that clocks the PipelineC core.
// Drives PLL RESETB and qualifies lock through a 2-flop synchronizer.
// Releases core reset only after lock has stayed high for a programmable time.
// Lock loss, timeout or force_restart reset the core and repeat bring-up.
// Optional build macro PLL_STARTUP_SEQ_LOCK_FILTER_EN: in RUN, a lock loss
// is declared only after LOCK_LOSS_FILTER consecutive lock-low cycles.
// Assumes MAX_RETRIES <= 3 so it fits the 2-bit retry_count port.
module pll_startup_seq #(
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int LOCK_LOSS_FILTER    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       force_restart,
    output logic       pll_resetb,
    output logic       core_rst_n,
    output logic [2:0] seq_state,
    output logic [1:0] retry_count,
    output logic [7:0] lock_loss_count,
    output logic       fault
);

    localparam int RST_W = (PLL_RESET_CYCLES    > 1) ? $clog2(PLL_RESET_CYCLES)    : 1;
    localparam int TO_W  = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
    localparam int STB_W = (LOCK_STABLE_CYCLES  > 1) ? $clog2(LOCK_STABLE_CYCLES)  : 1;

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RESET_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLL_RST   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

    state_e           state_q,      state_d;
    logic             sync1_q,      sync1_d;
    logic             lock_s_q,     lock_s_d;
    logic [RST_W-1:0] rst_cnt_q,    rst_cnt_d;
    logic [TO_W-1:0]  to_cnt_q,     to_cnt_d;
    logic [STB_W-1:0] stb_cnt_q,    stb_cnt_d;
    logic [1:0]       retry_q,      retry_d;
    logic [7:0]       loss_cnt_q,   loss_cnt_d;
    logic             pll_resetb_q, pll_resetb_d;
    logic             core_rst_n_q, core_rst_n_d;
    logic             fault_q,      fault_d;
    logic             lock_loss;
    logic [1:0]       retry_inc;

`ifdef PLL_STARTUP_SEQ_LOCK_FILTER_EN
    localparam int FLT_W = (LOCK_LOSS_FILTER > 1) ? $clog2(LOCK_LOSS_FILTER) : 1;
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOCK_LOSS_FILTER - 1);
    logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
`endif

    // Next-state, counter and registered-output logic for the bring-up FSM.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can leave it unassigned and infer a latch.
        state_d    = state_q;
        sync1_d    = pll_locked;
        lock_s_d   = sync1_q;
        rst_cnt_d  = rst_cnt_q;
        to_cnt_d   = to_cnt_q;
        stb_cnt_d  = stb_cnt_q;
        retry_d    = retry_q;
        loss_cnt_d = loss_cnt_q;
        lock_loss  = 1'b0;
        retry_inc  = retry_q + 2'd1;
`ifdef PLL_STARTUP_SEQ_LOCK_FILTER_EN
        flt_cnt_d  = flt_cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                state_d   = ST_PLL_RST;
                rst_cnt_d = '0;
            end
            ST_PLL_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d  = ST_WAIT_LOCK;
                    to_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d   = ST_STABLE;
                    stb_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    retry_d = retry_inc;
                    if (retry_inc == RETRY_MAX) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d   = ST_PLL_RST;
                        rst_cnt_d = '0;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_STABLE: begin
                // A dropout here resumes the same timeout window rather than starting a new attempt.
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (stb_cnt_q == STB_LAST) begin
                    state_d = ST_RUN;
                    retry_d = '0;
`ifdef PLL_STARTUP_SEQ_LOCK_FILTER_EN
                    flt_cnt_d = '0;
`endif
                end else begin
                    stb_cnt_d = stb_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
`ifdef PLL_STARTUP_SEQ_LOCK_FILTER_EN
                if (lock_s_q) begin
                    flt_cnt_d = '0;
                end else if (flt_cnt_q == FLT_LAST) begin
                    lock_loss = 1'b1;
                end else begin
                    flt_cnt_d = flt_cnt_q + 1'b1;
                end
`else
                lock_loss = !lock_s_q;
`endif
                if (lock_loss) begin
                    state_d   = ST_PLL_RST;
                    rst_cnt_d = '0;
                    if (loss_cnt_q != 8'hFF) begin
                        loss_cnt_d = loss_cnt_q + 8'd1;
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A restart request overrides whatever the state decided above.
        if (force_restart) begin
            state_d   = ST_PLL_RST;
            rst_cnt_d = '0;
            retry_d   = '0;
        end

        // Outputs are registered from the next state so they line up with state_q.
        pll_resetb_d = !(state_d inside {ST_IDLE, ST_PLL_RST, ST_FAULT});
        core_rst_n_d = (state_d == ST_RUN);
        fault_d      = (state_d == ST_FAULT);
    end

    // State, counter, synchronizer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            // NOTE: the synchronizer flops are reset too, so a stale lock cannot leak into the first decision.
            state_q      <= ST_IDLE;
            sync1_q      <= 1'b0;
            lock_s_q     <= 1'b0;
            rst_cnt_q    <= '0;
            to_cnt_q     <= '0;
            stb_cnt_q    <= '0;
            retry_q      <= '0;
            loss_cnt_q   <= '0;
            pll_resetb_q <= 1'b0;
            core_rst_n_q <= 1'b0;
            fault_q      <= 1'b0;
`ifdef PLL_STARTUP_SEQ_LOCK_FILTER_EN
            flt_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            lock_s_q     <= lock_s_d;
            rst_cnt_q    <= rst_cnt_d;
            to_cnt_q     <= to_cnt_d;
            stb_cnt_q    <= stb_cnt_d;
            retry_q      <= retry_d;
            loss_cnt_q   <= loss_cnt_d;
            pll_resetb_q <= pll_resetb_d;
            core_rst_n_q <= core_rst_n_d;
            fault_q      <= fault_d;
`ifdef PLL_STARTUP_SEQ_LOCK_FILTER_EN
            flt_cnt_q    <= flt_cnt_d;
`endif
        end
    end

    assign pll_resetb      = pll_resetb_q;
    assign core_rst_n      = core_rst_n_q;
    assign seq_state       = state_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_cnt_q;
    assign fault           = fault_q;

endmodule

// File: tb/tb_pll_startup_seq.sv
// Directed bench for pll_startup_seq with small sequencing limits.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pll_startup_seq;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRST = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_STB  = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;
    localparam logic [2:0] S_FLT  = 3'd5;

`ifdef PLL_STARTUP_SEQ_LOCK_FILTER_EN
    localparam int DROP_LEN = 4;
`else
    localparam int DROP_LEN = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       force_restart;
    logic       pll_resetb;
    logic       core_rst_n;
    logic [2:0] seq_state;
    logic [1:0] retry_count;
    logic [7:0] lock_loss_count;
    logic       fault;

    int total = 0;
    int bad   = 0;

    pll_startup_seq #(
        .PLL_RESET_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (32),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (2),
        .LOCK_LOSS_FILTER    (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pll_locked      (pll_locked),
        .force_restart   (force_restart),
        .pll_resetb      (pll_resetb),
        .core_rst_n      (core_rst_n),
        .seq_state       (seq_state),
        .retry_count     (retry_count),
        .lock_loss_count (lock_loss_count),
        .fault           (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance until seq_state equals s, bounded by budget cycles.
    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (seq_state !== s && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(seq_state), 32'(s));
    endtask

    // Count consecutive observed cycles spent in state s (bounded).
    task automatic count_state(input logic [2:0] s, output int n);
        n = 0;
        while (seq_state === s && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        int lows;

        rst_n         = 1'b0;
        pll_locked    = 1'b0;
        force_restart = 1'b0;
        repeat (3) tick();

        // Reset state.
        check("rst_state",      32'(seq_state),       32'(S_IDLE));
        check("rst_pll_resetb", 32'(pll_resetb),      0);
        check("rst_core_rst_n", 32'(core_rst_n),      0);
        check("rst_retry",      32'(retry_count),     0);
        check("rst_loss",       32'(lock_loss_count), 0);
        check("rst_fault",      32'(fault),           0);

        // Nominal bring-up: IDLE one cycle, PLL_RST four, lock driven at cycle 10.
        rst_n = 1'b1;
        tick();
        check("nom_enter_prst", 32'(seq_state), 32'(S_PRST));
        check("nom_prst_resetb", 32'(pll_resetb), 0);
        count_state(S_PRST, n);
        check("nom_prst_len", 32'(n), 4);
        check("nom_wait_state", 32'(seq_state), 32'(S_WAIT));
        check("nom_wait_resetb", 32'(pll_resetb), 1);
        repeat (5) tick();
        check("nom_still_wait", 32'(seq_state), 32'(S_WAIT));
        pll_locked = 1'b1;
        n = 0;
        while (seq_state !== S_STB && n < 20) begin
            tick();
            n++;
        end
        check("nom_lock_to_stable", 32'(n), 3);
        check("nom_stable_core", 32'(core_rst_n), 0);
        count_state(S_STB, n);
        check("nom_stable_len", 32'(n), 8);
        check("nom_run_state", 32'(seq_state), 32'(S_RUN));
        check("nom_run_core", 32'(core_rst_n), 1);
        check("nom_run_retry", 32'(retry_count), 0);

        // Lock chatter: high 5, low 1, high again.
        force_restart = 1'b1;
        pll_locked    = 1'b0;
        tick();
        force_restart = 1'b0;
        check("chat_force_prst", 32'(seq_state), 32'(S_PRST));
        check("chat_force_core", 32'(core_rst_n), 0);
        check("chat_force_loss", 32'(lock_loss_count), 0);
        count_state(S_PRST, n);
        check("chat_prst_len", 32'(n), 4);
        pll_locked = 1'b1;
        repeat (5) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        check("chat_in_stable", 32'(seq_state), 32'(S_STB));
        wait_state(S_WAIT, 5, "chat_back_wait");
        check("chat_no_retry", 32'(retry_count), 0);
        wait_state(S_STB, 5, "chat_restable");
        count_state(S_STB, n);
        check("chat_stable_len", 32'(n), 8);
        check("chat_run_core", 32'(core_rst_n), 1);

        // Timeout to FAULT with lock held low.
        pll_locked    = 1'b0;
        force_restart = 1'b1;
        tick();
        force_restart = 1'b0;
        count_state(S_PRST, n);
        check("to_prst1_len", 32'(n), 4);
        count_state(S_WAIT, n);
        check("to_wait1_len", 32'(n), 32);
        check("to_retry1_state", 32'(seq_state), 32'(S_PRST));
        check("to_retry1_cnt", 32'(retry_count), 1);
        check("to_retry1_resetb", 32'(pll_resetb), 0);
        count_state(S_PRST, n);
        check("to_prst2_len", 32'(n), 4);
        count_state(S_WAIT, n);
        check("to_wait2_len", 32'(n), 32);
        check("to_fault_state", 32'(seq_state), 32'(S_FLT));
        check("to_fault_flag", 32'(fault), 1);
        check("to_fault_retry", 32'(retry_count), 2);
        check("to_fault_resetb", 32'(pll_resetb), 0);
        repeat (10) tick();
        check("to_fault_hold", 32'(seq_state), 32'(S_FLT));
        check("to_fault_core", 32'(core_rst_n), 0);

        // Recovery from FAULT.
        force_restart = 1'b1;
        pll_locked    = 1'b1;
        tick();
        force_restart = 1'b0;
        check("rec_prst", 32'(seq_state), 32'(S_PRST));
        check("rec_retry_clr", 32'(retry_count), 0);
        check("rec_fault_clr", 32'(fault), 0);
        wait_state(S_RUN, 40, "rec_reach_run");
        check("rec_core", 32'(core_rst_n), 1);

        // RUN lock loss.
`ifdef PLL_STARTUP_SEQ_LOCK_FILTER_EN
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        lows = 0;
        repeat (6) begin
            tick();
            if (core_rst_n !== 1'b1) lows++;
        end
        check("flt_glitch3_ignored", 32'(lows), 0);
        check("flt_glitch3_loss", 32'(lock_loss_count), 0);
        pll_locked = 1'b0;
        repeat (4) tick();
        pll_locked = 1'b1;
        tick();
        check("flt_drop4_core_hold", 32'(core_rst_n), 1);
        tick();
        check("flt_drop4_core_low", 32'(core_rst_n), 0);
        check("flt_drop4_state", 32'(seq_state), 32'(S_PRST));
        check("flt_drop4_loss", 32'(lock_loss_count), 1);
`else
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        check("loss_core_hold", 32'(core_rst_n), 1);
        tick();
        check("loss_core_low", 32'(core_rst_n), 0);
        check("loss_state", 32'(seq_state), 32'(S_PRST));
        check("loss_count", 32'(lock_loss_count), 1);
`endif
        wait_state(S_RUN, 40, "loss_rerun");

        // Saturation of lock_loss_count.
        for (int i = 0; i < 260; i++) begin
            pll_locked = 1'b0;
            repeat (DROP_LEN) tick();
            pll_locked = 1'b1;
            wait_state(S_PRST, 10, "sat_leave_run");
            wait_state(S_RUN, 40, "sat_rerun");
            if (i == 252) check("sat_count_254", 32'(lock_loss_count), 254);
        end
        check("sat_count_255", 32'(lock_loss_count), 255);

        // force_restart on the cycle STABLE would complete.
        force_restart = 1'b1;
        tick();
        force_restart = 1'b0;
        wait_state(S_STB, 20, "pri_reach_stable");
        repeat (7) tick();
        check("pri_last_stable", 32'(seq_state), 32'(S_STB));
        force_restart = 1'b1;
        tick();
        force_restart = 1'b0;
        check("pri_prst_not_run", 32'(seq_state), 32'(S_PRST));
        check("pri_core", 32'(core_rst_n), 0);

        // A pulse inside PLL_RST restarts its cycle count.
        repeat (2) tick();
        force_restart = 1'b1;
        tick();
        force_restart = 1'b0;
        count_state(S_PRST, n);
        check("prst_restart_len", 32'(n), 4);
        check("prst_loss_kept", 32'(lock_loss_count), 255);

        // Synchronous reset mid-sequence.
        wait_state(S_STB, 10, "mid_reach_stable");
        rst_n = 1'b0;
        tick();
        check("mid_rst_state", 32'(seq_state), 32'(S_IDLE));
        check("mid_rst_resetb", 32'(pll_resetb), 0);
        check("mid_rst_loss", 32'(lock_loss_count), 0);
        check("mid_rst_retry", 32'(retry_count), 0);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_startup_seq.md
Name: pll_startup_seq

Overview:
- Sequences the iCE40 PLL that generates the PipelineC core clock from the 12 MHz board clock on ICE_35.
- Drives the PLL's active-low reset, qualifies its lock output, and releases the core reset only after lock has been stable.
- On lock loss, timeout or a restart request it resets the core and re-runs PLL bring-up.
- Runs in the 12 MHz reference domain, between the PLL instance and the pipelinec_top reset input.

Parameters:
- PLL_RESET_CYCLES, 16, cycles pll_resetb is held low per bring-up attempt (min 1).
- LOCK_TIMEOUT_CYCLES, 65536, max cycles in WAIT_LOCK before the attempt fails.
- LOCK_STABLE_CYCLES, 1024, consecutive synced-lock-high cycles required before RUN.
- MAX_RETRIES, 3, failed attempts allowed before FAULT (min 1).
- LOCK_LOSS_FILTER, 4, consecutive lock-low cycles needed in RUN; used only with the optional feature.

Ports:
- clk  in  1  12 MHz reference clock.
- rst_n  in  1  synchronous active-low reset.
- pll_locked  in  1  raw PLL lock, asynchronous to clk.
- force_restart  in  1  single-cycle pulse; restarts the bring-up sequence.
- pll_resetb  out  1  PLL RESETB, active low.
- core_rst_n  out  1  core reset, active low; the consumer re-synchronizes it into pll_clk.
- seq_state  out  3  current state encoding.
- retry_count  out  2  failed attempts in the current bring-up.
- lock_loss_count  out  8  RUN-state lock losses since rst_n; saturates at 255.
- fault  out  1  high while in FAULT.

Behaviour:
- Clock and reset
  - Single clock clk; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
  - Reset values: state IDLE, pll_resetb=0, core_rst_n=0, retry_count=0, lock_loss_count=0, fault=0, all counters 0, synchronizer flops 0.
- Lock synchronizer
  - pll_locked passes through a 2-flop synchronizer; lock_s is the second flop.
  - Every decision below uses lock_s only, so there is 2 cycles of latency from pll_locked.
- State encoding: IDLE=0, PLL_RST=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5.
- IDLE
  - Lasts 1 cycle, then PLL_RST.
- PLL_RST
  - pll_resetb=0 for exactly PLL_RESET_CYCLES cycles, then WAIT_LOCK.
  - The timeout counter clears on entry to WAIT_LOCK.
- WAIT_LOCK
  - pll_resetb=1; the timeout counter increments each cycle.
  - lock_s=1: go to STABLE with the stable counter at 0.
  - Timeout counter reaches LOCK_TIMEOUT_CYCLES-1 with lock_s=0: retry_count increments.
    - New retry_count == MAX_RETRIES: go to FAULT.
    - Otherwise: go to PLL_RST.
- STABLE
  - The stable counter increments while lock_s=1.
  - lock_s=0: return to WAIT_LOCK; the timeout counter is not cleared; no retry is counted.
  - Counter reaches LOCK_STABLE_CYCLES-1 with lock_s=1: go to RUN; retry_count clears.
- RUN
  - core_rst_n=1, registered, so it rises the cycle RUN is entered.
  - lock_s=0: the next cycle is PLL_RST with core_rst_n=0.
  - lock_loss_count increments, saturating at 255.
- FAULT
  - pll_resetb=0, core_rst_n=0, fault=1; the block stays here until force_restart or rst_n.
- core_rst_n is 1 only in RUN; pll_resetb is 0 only in IDLE, PLL_RST and FAULT.
- force_restart
  - Takes effect in any state and has priority over all other transitions.
  - Next state PLL_RST; retry_count clears; core_rst_n=0.
  - lock_loss_count is unchanged.
  - A pulse while already in PLL_RST restarts that state's cycle count.
- Simultaneous events
  - Lock drop and timeout on the same cycle in WAIT_LOCK: the timeout path wins.
  - rst_n=0 overrides everything, including mid-sequence.
- Counter widths: $clog2 of each limit, minimum 1 bit. No wrap is possible because every counter is bounded by its terminal-count transition.

Optional Feature:
- Macro PLL_STARTUP_SEQ_LOCK_FILTER_EN.
- Defined: in RUN, a lock loss is declared only after lock_s=0 for LOCK_LOSS_FILTER consecutive cycles.
  - The filter counter clears whenever lock_s=1 and on RUN entry.
  - Shorter glitches are ignored; core_rst_n stays 1.
- Undefined: a single cycle of lock_s=0 in RUN is a lock loss. The LOCK_LOSS_FILTER parameter is unused.

Test Plan:
- Sim parameters for all scenarios: PLL_RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
- Nominal bring-up: release rst_n, pll_locked=1 from cycle 10 -> pll_resetb low exactly 4 cycles; core_rst_n rises 8 cycles after lock_s=1; seq_state=4.
- Lock chatter: lock high 5 cycles, low 1, then high -> back to WAIT_LOCK, no retry counted; core_rst_n rises 8 cycles after final lock_s rise.
- Timeout to FAULT: pll_locked held 0 -> two 4-cycle PLL_RST pulses separated by 32-cycle waits; then fault=1, retry_count=2, core_rst_n=0 persistent.
- Recovery: in FAULT pulse force_restart, then pll_locked=1 -> retry_count=0, reaches RUN.
- Run lock loss: in RUN drop pll_locked for 1 cycle -> core_rst_n=0 within 3 cycles of the drop, lock_loss_count=1, full re-sequence.
  - With PLL_STARTUP_SEQ_LOCK_FILTER_EN and LOCK_LOSS_FILTER=4: a 3-cycle drop is ignored; a 4-cycle drop resets the core.
- Saturation/priority: 260 RUN lock losses -> lock_loss_count=255; force_restart on the same cycle as STABLE completion -> PLL_RST, not RUN.
